// File: rtl/cmd_encoder.sv
// Serialises one parallel levitator command into a 3-byte AXI-stream frame and,
// for query/ping ops, waits for the single reply byte with a cycle timeout.
module cmd_encoder #(
  parameter int OUTPUTS    = 88,
  parameter int TIMEOUT    = 50000,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [6:0]            cmd_channel,
  input  logic [11:0]           cmd_offset,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_valid,
  output logic                  resp_timeout,
  output logic                  cmd_err,
  output logic                  busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Decided one cycle early so the registered pulse lands TIMEOUT cycles after B2.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, WAIT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [6:0]    r_ch;
  logic [11:0]   r_off;
  logic [CW-1:0] r_count;
  logic          w_cmdFire;
  logic          w_reject;
  logic          w_b2Fire;
  logic          w_rxHit;
  logic          w_timeoutHit;

  always_comb begin
    w_next             = r_state;
    cmd_ready          = 1'b0;
    output_axis_tvalid = 1'b0;
    output_axis_tdata  = '0;
    busy               = 1'b0;
    input_axis_tready  = rst;
    w_cmdFire          = 1'b0;
    w_reject           = 1'b0;
    w_b2Fire           = 1'b0;
    w_rxHit            = 1'b0;
    w_timeoutHit       = 1'b0;
    // Every output is forced quiet while reset is held low.
    if (rst) begin
      busy = (r_state != IDLE);
      case (r_state)
        IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            w_cmdFire = 1'b1;
            w_reject  = (cmd_op == 2'b00) && (32'(cmd_channel) >= OUTPUTS);
            if (!w_reject) w_next = B0;
          end
        end
        B0: begin
          output_axis_tvalid = 1'b1;
          output_axis_tdata  = {1'b1, r_op, r_ch[6:2]};
          if (output_axis_tready) w_next = B1;
        end
        B1: begin
          output_axis_tvalid = 1'b1;
          output_axis_tdata  = {1'b0, r_ch[1:0], r_off[11:7]};
          if (output_axis_tready) w_next = B2;
        end
        B2: begin
          output_axis_tvalid = 1'b1;
          output_axis_tdata  = {1'b0, r_off[6:0]};
          if (output_axis_tready) begin
            w_b2Fire = 1'b1;
            w_next   = r_op[1] ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (input_axis_tvalid) begin
            w_rxHit = 1'b1;
            w_next  = IDLE;
          end else if (r_count == LAST) begin
            w_timeoutHit = 1'b1;
            w_next       = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_ch         <= '0;
      r_off        <= '0;
      r_count      <= '0;
      resp_data    <= '0;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      r_state      <= w_next;
      cmd_err      <= w_cmdFire && w_reject;
      resp_valid   <= w_rxHit;
      resp_timeout <= w_timeoutHit;
      if (w_rxHit) resp_data <= input_axis_tdata;
      // Non-offset ops carry zero channel/offset fields on the wire.
      if (w_cmdFire && !w_reject) begin
        r_op  <= cmd_op;
        r_ch  <= (cmd_op == 2'b00) ? cmd_channel : '0;
        r_off <= (cmd_op == 2'b00) ? cmd_offset : '0;
      end
      if (w_b2Fire) r_count <= '0;
      else if (r_state == WAIT) r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_encoder.sv
// Bench for cmd_encoder: a transaction-level model of the protocol is checked
// against the DUT every cycle, plus literal frame/latency expectations.
module tb_cmd_encoder;

  localparam int OUTPUTS = 88;
  localparam int TO      = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [6:0]  cmd_channel;
  logic [11:0] cmd_offset;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready;
  logic [7:0]  input_axis_tdata;
  logic        input_axis_tvalid;
  logic        input_axis_tready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_timeout;
  logic        cmd_err;
  logic        busy;

  cmd_encoder #(.OUTPUTS(OUTPUTS), .TIMEOUT(TO), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_channel(cmd_channel), .cmd_offset(cmd_offset),
    .output_axis_tdata(output_axis_tdata), .output_axis_tvalid(output_axis_tvalid),
    .output_axis_tready(output_axis_tready),
    .input_axis_tdata(input_axis_tdata), .input_axis_tvalid(input_axis_tvalid),
    .input_axis_tready(input_axis_tready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_timeout(resp_timeout),
    .cmd_err(cmd_err), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int treadyMode = 0;

  logic [7:0] mQ[$];
  logic [7:0] txLog[$];
  logic       mWaiting = 1'b0;
  int         mDeadline = 0;
  int         mOp = 0;
  logic       errPend = 1'b0;
  logic       rvPend = 1'b0;
  logic       toPend = 1'b0;
  logic [7:0] mRespData = 8'h00;
  int txCount = 0, acceptCount = 0, b2Cycle = 0;
  int rvCycle = 0, toCycle = 0, rvCount = 0, toCount = 0, errCount = 0;
  logic [7:0] lastResp = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  // Frame bytes straight from the protocol's field layout, in plain arithmetic.
  task automatic pushFrame(input int op, input int ch, input int off);
    int c, o;
    c = (op == 0) ? ch : 0;
    o = (op == 0) ? off : 0;
    mQ.push_back(8'(128 + op * 32 + c / 4));
    mQ.push_back(8'((c % 4) * 32 + o / 128));
    mQ.push_back(8'(o % 128));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_tvalid", output_axis_tvalid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_tready", input_axis_tready, 1'b0);
      mQ.delete();
      mWaiting  = 1'b0;
      errPend   = 1'b0;
      rvPend    = 1'b0;
      toPend    = 1'b0;
      mRespData = 8'h00;
    end else begin
      logic mBusy;
      check("cmd_err", cmd_err, errPend);
      check("resp_valid", resp_valid, rvPend);
      check("resp_timeout", resp_timeout, toPend);
      check("resp_data", resp_data, mRespData);
      if (resp_valid) begin rvCycle = cyc; rvCount++; lastResp = resp_data; end
      if (resp_timeout) begin toCycle = cyc; toCount++; end
      if (cmd_err) errCount++;
      errPend = 1'b0;
      rvPend  = 1'b0;
      toPend  = 1'b0;
      mBusy = (mQ.size() > 0) || mWaiting;
      check("busy", busy, mBusy);
      check("cmd_ready", cmd_ready, !mBusy);
      check("in_tready", input_axis_tready, 1'b1);
      check("tvalid", output_axis_tvalid, mQ.size() > 0);
      if (mQ.size() > 0) check("tdata", output_axis_tdata, mQ[0]);
      if (output_axis_tvalid && output_axis_tready) txLog.push_back(output_axis_tdata);
      if (mQ.size() > 0) begin
        if (output_axis_tready) begin
          void'(mQ.pop_front());
          txCount++;
          if (mQ.size() == 0) begin
            b2Cycle = cyc;
            if (mOp >= 2) begin mWaiting = 1'b1; mDeadline = cyc + TO; end
          end
        end
      end else if (mWaiting) begin
        if (input_axis_tvalid) begin
          rvPend = 1'b1; mRespData = input_axis_tdata; mWaiting = 1'b0;
        end else if (cyc == mDeadline - 1) begin
          toPend = 1'b1; mWaiting = 1'b0;
        end
      end else if (cmd_valid) begin
        acceptCount++;
        if (cmd_op == 2'b00 && int'(cmd_channel) >= OUTPUTS) errPend = 1'b1;
        else begin
          mOp = int'(cmd_op);
          pushFrame(int'(cmd_op), int'(cmd_channel), int'(cmd_offset));
        end
      end
    end
  end

  initial begin
    output_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      output_axis_tready = (treadyMode != 0) ? ~output_axis_tready : 1'b1;
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] ch, input logic [11:0] off);
    int start;
    bit ok;
    start = acceptCount;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_channel = ch; cmd_offset = off;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (acceptCount != start) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (mQ.size() == 0 && !mWaiting && !errPend && !rvPend && !toPend) begin ok = 1'b1; break; end
    end
    if (!ok) failNow("wait_idle");
  endtask

  task automatic waitTx(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (txCount >= target) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    if (!ok) failNow("wait_tx");
  endtask

  task automatic driveRx(input int d, input logic [7:0] val);
    repeat (d) @(posedge clk);
    #1;
    input_axis_tvalid = 1'b1; input_axis_tdata = val;
    @(posedge clk); #1;
    input_axis_tvalid = 1'b0; input_axis_tdata = 8'h00;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    check({name, "_len"}, txLog.size(), 3);
    if (txLog.size() == 3) begin
      check({name, "_b0"}, txLog[0], a);
      check({name, "_b1"}, txLog[1], b);
      check({name, "_b2"}, txLog[2], c);
    end
    txLog.delete();
  endtask

  initial begin
    int n;
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_channel = 7'd0; cmd_offset = 12'd0;
    input_axis_tvalid = 1'b0; input_axis_tdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_resp", resp_data, 8'h00);

    applyStimulus(2'b00, 7'd85, 12'hABC);
    waitIdle();
    checkOutput("setoff", 8'h95, 8'h35, 8'h3C);

    treadyMode = 1;
    applyStimulus(2'b00, 7'd85, 12'hABC);
    waitIdle();
    treadyMode = 0;
    checkOutput("setoff_bp", 8'h95, 8'h35, 8'h3C);

    applyStimulus(2'b01, 7'd85, 12'hABC);
    waitIdle();
    checkOutput("reload", 8'hA0, 8'h00, 8'h00);

    applyStimulus(2'b00, 7'd87, 12'h000);
    waitIdle();
    checkOutput("ch87", 8'h95, 8'h60, 8'h00);

    n = txCount;
    applyStimulus(2'b10, 7'd5, 12'h123);
    waitTx(n + 3);
    driveRx(5, 8'h58);
    waitIdle();
    checkOutput("query", 8'hC0, 8'h00, 8'h00);
    check("query_resp", lastResp, 8'h58);
    check("query_lat", rvCycle - b2Cycle, 6);

    driveRx(1, 8'h77);
    waitIdle();
    check("idle_rx_keep", resp_data, 8'h58);

    n = txCount;
    applyStimulus(2'b11, 7'd0, 12'h000);
    waitTx(n + 3);
    driveRx(2, 8'h00);
    waitIdle();
    checkOutput("ping", 8'hE0, 8'h00, 8'h00);
    check("ping_resp", lastResp, 8'h00);

    n = txCount;
    applyStimulus(2'b10, 7'd0, 12'h000);
    waitTx(n + 3);
    waitIdle();
    txLog.delete();
    check("timeout_lat", toCycle - b2Cycle, TO);
    check("timeout_cnt", toCount, 1);

    n = txCount;
    applyStimulus(2'b10, 7'd0, 12'h000);
    waitTx(n + 3);
    driveRx(TO - 1, 8'h3A);
    waitIdle();
    txLog.delete();
    check("edge_lat", rvCycle - b2Cycle, TO);
    check("edge_no_to", toCount, 1);
    check("edge_resp", lastResp, 8'h3A);

    applyStimulus(2'b00, 7'd88, 12'h456);
    waitIdle();
    check("reject_cnt", errCount, 1);
    check("reject_notx", txLog.size(), 0);

    n = txCount;
    applyStimulus(2'b00, 7'd85, 12'hABC);
    waitTx(n + 1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    check("trunc_len", txLog.size(), 1);
    txLog.delete();
    applyStimulus(2'b01, 7'd3, 12'h0FF);
    waitIdle();
    checkOutput("after_rst", 8'hA0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    failNow("watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
